write_resp_router: RTL

- Write-response (B channel) return path for the 2-master AXI interconnect; the counterpart to the write-address arbitration stage.
- Records, in grant order, which master won each accepted AW transfer.
- Steers the single shared slave-side B channel back to the correct master in that same order.
- Bounds outstanding writes and flags protocol violations.

---
 rtl/write_resp_router.sv | 104 ++++++++++
 1 files changed

// File: rtl/write_resp_router.sv
// B-channel return path: records AW grant order in a small FIFO and steers the shared
// slave-side write response back to the owning master in that order.
module write_resp_router #(
  parameter int unsigned Max_Outstanding = 4,
  parameter int unsigned Resp_Width      = 2,
  parameter int unsigned Cnt_Width       = $clog2(Max_Outstanding + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  AW_Grant_Valid,
  input  logic                  AW_Grant_Master,
  output logic                  AW_Accept_Allowed,
  input  logic                  M00_AXI_bvalid,
  input  logic [Resp_Width-1:0] M00_AXI_bresp,
  output logic                  M00_AXI_bready,
  output logic                  S00_AXI_bvalid,
  output logic [Resp_Width-1:0] S00_AXI_bresp,
  input  logic                  S00_AXI_bready,
  output logic                  S01_AXI_bvalid,
  output logic [Resp_Width-1:0] S01_AXI_bresp,
  input  logic                  S01_AXI_bready,
  output logic [Cnt_Width-1:0]  Outstanding_Count,
  output logic                  Overflow_Err,
  output logic                  Unexpected_Resp
);

  localparam int unsigned PtrW = $clog2(Max_Outstanding);

  logic [Max_Outstanding-1:0] fifo_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [Cnt_Width-1:0]       count_q;
  logic                       overflow_q, unexpected_q;

  logic full, empty, head, push, pop;

  always_comb begin
    full  = (count_q == Cnt_Width'(Max_Outstanding));
    empty = (count_q == '0);
    head  = fifo_q[rd_ptr_q];
  end

  // Routing is purely combinational off the registered head entry.
  always_comb begin
    S00_AXI_bvalid = 1'b0;
    S01_AXI_bvalid = 1'b0;
    S00_AXI_bresp  = '0;
    S01_AXI_bresp  = '0;
    M00_AXI_bready = 1'b0;
    if (!empty) begin
      if (head == 1'b0) begin
        S00_AXI_bvalid = M00_AXI_bvalid;
        S00_AXI_bresp  = M00_AXI_bresp;
        M00_AXI_bready = S00_AXI_bready;
      end else begin
        S01_AXI_bvalid = M00_AXI_bvalid;
        S01_AXI_bresp  = M00_AXI_bresp;
        M00_AXI_bready = S01_AXI_bready;
      end
    end
  end

  always_comb begin
    pop  = M00_AXI_bvalid && M00_AXI_bready;
    // A same-edge pop frees the slot, so a push into a full FIFO is accepted then.
    push = AW_Grant_Valid && (!full || pop);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      unexpected_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= AW_Grant_Master;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + Cnt_Width'(1);
      end else if (pop && !push) begin
        count_q <= count_q - Cnt_Width'(1);
      end
      if (AW_Grant_Valid && !push) begin
        overflow_q <= 1'b1;
      end
      // A grant arriving alongside the stray response makes it legitimate next cycle.
      if (empty && M00_AXI_bvalid && !AW_Grant_Valid) begin
        unexpected_q <= 1'b1;
      end
    end
  end

  assign AW_Accept_Allowed = !full;
  assign Outstanding_Count = count_q;
  assign Overflow_Err      = overflow_q;
  assign Unexpected_Resp   = unexpected_q;

endmodule
